// File: rtl/hwag.sv
// HWAG: crank-wheel tooth tracker for a 60-2 trigger wheel.
// Synchronises the VR tooth input, measures tooth periods, finds the
// missing-tooth gap and reports when the wheel position is locked.
module hwag #(
    parameter int TEETH_PRESENT = 58,
    parameter int PERIOD_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic cap,
    output logic second_edge,
    output logic hwag_start
);

    localparam int TOOTH_W = $clog2(TEETH_PRESENT);
    localparam logic [TOOTH_W-1:0] LAST_TOOTH = TOOTH_W'(TEETH_PRESENT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        SEARCH = 3'd2,
        COUNT  = 3'd3,
        SYNC   = 3'd4
    } state_t;

    // An interval is a gap when it is more than twice the previous one.
    // Both sides are widened by one bit so the doubling cannot overflow.
    function automatic logic is_gap(input logic [PERIOD_W-1:0] cur,
                                    input logic [PERIOD_W-1:0] prev);
        return ({1'b0, cur} > {prev, 1'b0});
    endfunction

    logic                sync1_r;
    logic                sync2_r;
    logic                cap_d_r;
    logic                fill1_r;
    logic                fill2_r;
    logic                armed_r;
    logic                edge_s;
    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] prev_period_r;
    logic                sat_s;
    logic                gap_s;
    logic                last_s;
    state_t              state_r;
    state_t              state_n;
    logic [TOOTH_W-1:0]  tooth_r;
    logic [TOOTH_W-1:0]  tooth_n;
    logic                strobe_n;
    logic                start_n;
    logic                second_edge_r;
    logic                hwag_start_r;

    // Two-flop synchroniser, edge register, and an arming flag that only
    // sets once a genuine low sample has come through the chain, so a cap
    // already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cap_d_r <= 1'b0;
            fill1_r <= 1'b0;
            fill2_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= cap;
            sync2_r <= sync1_r;
            cap_d_r <= sync2_r;
            fill1_r <= 1'b1;
            fill2_r <= fill1_r;
            armed_r <= armed_r | (fill2_r & ~sync2_r);
        end
    end

    assign edge_s = sync2_r & ~cap_d_r & armed_r;
    assign sat_s  = &cnt_r;

    // At an edge the running counter holds the interval that just ended
    // (the current period) and prev_period_r holds the one before it.
    assign gap_s  = is_gap(cnt_r, prev_period_r);
    assign last_s = (tooth_r == LAST_TOOTH);

    // Saturating period counter; restarts at 1 on each edge and latches the
    // finished interval for the next gap comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r         <= {PERIOD_W{1'b0}};
            prev_period_r <= {PERIOD_W{1'b0}};
        end else if (edge_s) begin
            cnt_r         <= PERIOD_W'(1);
            prev_period_r <= cnt_r;
        end else if (!sat_s) begin
            cnt_r         <= cnt_r + PERIOD_W'(1);
        end else begin
            cnt_r         <= cnt_r;
        end
    end

    // Next-state, tooth count and strobe decisions for each qualified edge.
    always_comb begin
        state_n  = state_r;
        tooth_n  = tooth_r;
        strobe_n = 1'b0;
        if (sat_s && (state_r != IDLE)) begin
            // Stall: drop back; a coinciding edge becomes the first edge.
            tooth_n = {TOOTH_W{1'b0}};
            if (edge_s) begin
                state_n = FIRST;
            end else begin
                state_n = IDLE;
            end
        end else if (edge_s) begin
            case (state_r)
                IDLE: begin
                    state_n = FIRST;
                    tooth_n = {TOOTH_W{1'b0}};
                end
                FIRST: begin
                    strobe_n = 1'b1;
                    state_n  = SEARCH;
                    tooth_n  = {TOOTH_W{1'b0}};
                end
                SEARCH: begin
                    strobe_n = 1'b1;
                    tooth_n  = {TOOTH_W{1'b0}};
                    if (gap_s) begin
                        state_n = COUNT;
                    end else begin
                        state_n = SEARCH;
                    end
                end
                COUNT, SYNC: begin
                    strobe_n = 1'b1;
                    if (gap_s) begin
                        tooth_n = {TOOTH_W{1'b0}};
                        if (last_s) begin
                            state_n = SYNC;
                        end else begin
                            state_n = COUNT;
                        end
                    end else if (last_s) begin
                        tooth_n = {TOOTH_W{1'b0}};
                        state_n = SEARCH;
                    end else begin
                        tooth_n = tooth_r + TOOTH_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    tooth_n = {TOOTH_W{1'b0}};
                end
            endcase
        end else begin
            state_n = state_r;
        end
        start_n = (state_n == SYNC);
    end

    // State, tooth counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            tooth_r       <= {TOOTH_W{1'b0}};
            second_edge_r <= 1'b0;
            hwag_start_r  <= 1'b0;
        end else begin
            state_r       <= state_n;
            tooth_r       <= tooth_n;
            second_edge_r <= strobe_n;
            hwag_start_r  <= start_n;
        end
    end

    assign second_edge = second_edge_r;
    assign hwag_start  = hwag_start_r;

endmodule

// File: tb/tb_hwag.sv
// Directed bench for hwag: tables of tooth intervals with hand-derived
// expected strobe/sync values, plus hand-written stall and reset sequences.
// A short period counter keeps the saturation case within a small run.
module tb_hwag;

    localparam int TEETH = 58;
    localparam int PW    = 10;
    localparam int T     = 16;
    localparam int G     = 48;

    logic clk = 1'b0;
    logic rst;
    logic cap;
    logic second_edge;
    logic hwag_start;

    hwag #(.TEETH_PRESENT(TEETH), .PERIOD_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cap         (cap),
        .second_edge (second_edge),
        .hwag_start  (hwag_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   period;
        logic exp_se;
        logic exp_hs;
    } vec_t;

    vec_t vq[$];
    int applied = 0;
    int errs    = 0;
    int elapsed = 0;
    int vidx    = 0;
    int tper;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            elapsed++;
        end
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
        end
    endtask

    function automatic void push(input int p, input logic se, input logic hs);
        vec_t v;
        v.period = p;
        v.exp_se = se;
        v.exp_hs = hs;
        vq.push_back(v);
    endfunction

    function automatic void push_teeth(input int n, input int p, input logic se, input logic hs);
        for (int i = 0; i < n; i++) push(p, se, hs);
    endfunction

    // Each record: wait until 'period' clk since the previous rise, raise
    // cap, check the registered outputs 3 clk later and the strobe width.
    task automatic run_table();
        for (int i = 0; i < vq.size(); i++) begin
            while (elapsed < vq[i].period) tick(1);
            cap = 1'b1;
            elapsed = 0;
            tick(3);
            chk("strobe", vidx, second_edge, vq[i].exp_se);
            chk("start", vidx, hwag_start, vq[i].exp_hs);
            tick(1);
            chk("strobe_width", vidx, second_edge, 1'b0);
            tick(2);
            cap = 1'b0;
            vidx++;
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b0;
        cap = 1'b0;

        // Reset held while cap toggles: outputs stay low.
        for (int i = 0; i < 6; i++) begin
            cap = ~cap;
            tick(3);
            chk("rst_strobe", i, second_edge, 1'b0);
            chk("rst_start", i, hwag_start, 1'b0);
        end

        // Release reset with cap already high; that level is not an edge.
        cap = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(20);
        chk("held_high_strobe", 0, second_edge, 1'b0);
        cap = 1'b0;
        elapsed = 0;

        // Uniform teeth: no strobe on the first edge, then one per edge.
        push(20, 1'b0, 1'b0);
        push_teeth(5, T, 1'b1, 1'b0);
        // 60-2 wheel from a few teeth before the gap.
        push_teeth(3, T, 1'b1, 1'b0);
        push(G, 1'b1, 1'b0);
        push_teeth(57, T, 1'b1, 1'b0);
        push(G, 1'b1, 1'b1);
        push_teeth(57, T, 1'b1, 1'b1);
        push(G, 1'b1, 1'b1);
        // Early gap after tooth 50 drops sync, next good revolution restores it.
        push_teeth(50, T, 1'b1, 1'b1);
        push(G, 1'b1, 1'b0);
        push_teeth(57, T, 1'b1, 1'b0);
        push(G, 1'b1, 1'b1);
        // Missing gap: a 58th normal tooth drops sync into search.
        push_teeth(57, T, 1'b1, 1'b1);
        push(T, 1'b1, 1'b0);
        push(G, 1'b1, 1'b0);
        push_teeth(57, T, 1'b1, 1'b0);
        push(G, 1'b1, 1'b1);
        run_table();

        // Stall in sync: counter saturates 1025 clk after the last rise.
        while (elapsed < 1020) tick(1);
        chk("stall_pre", 0, hwag_start, 1'b1);
        while (elapsed < 1030) tick(1);
        chk("stall_post", 0, hwag_start, 1'b0);
        chk("stall_strobe", 0, second_edge, 1'b0);
        push(1100, 1'b0, 1'b0);
        push(T, 1'b1, 1'b0);
        push(T, 1'b1, 1'b0);
        run_table();

        // Fresh start, tooth period shrinking by one clk per tooth, gap 3x.
        tick(1);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        elapsed = 0;
        tper = 260;
        push(20, 1'b0, 1'b0);
        push(tper, 1'b1, 1'b0);
        tper--;
        for (int i = 0; i < 2; i++) begin
            push(tper, 1'b1, 1'b0);
            tper--;
        end
        push(3 * tper, 1'b1, 1'b0);
        for (int i = 0; i < 57; i++) begin
            push(tper, 1'b1, 1'b0);
            tper--;
        end
        push(3 * tper, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 57; i++) begin
                push(tper, 1'b1, 1'b1);
                tper--;
            end
            push(3 * tper, 1'b1, 1'b1);
        end
        run_table();

        // Reset asserted mid-cycle drops hwag_start before any clk edge.
        tick(1);
        chk("pre_reset_start", 0, hwag_start, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_start", 0, hwag_start, 1'b0);
        chk("async_reset_strobe", 0, second_edge, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
